// File: rtl/lc3b_scoreboard.sv
// Writer-side hazard scoreboard: per-register and CC pending-write counters that
// drive the decode-stage dependency stall.
module lc3b_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        issue,
  input  logic                        issue_ld_reg,
  input  logic [$clog2(NUM_REGS)-1:0] issue_drid,
  input  logic                        issue_ld_cc,
  input  logic                        retire,
  input  logic                        retire_ld_reg,
  input  logic [$clog2(NUM_REGS)-1:0] retire_drid,
  input  logic                        retire_ld_cc,
  input  logic                        flush,
  input  logic                        q_valid,
  input  logic [$clog2(NUM_REGS)-1:0] q_sr1,
  input  logic                        q_sr1_needed,
  input  logic [$clog2(NUM_REGS)-1:0] q_sr2,
  input  logic                        q_sr2_needed,
  input  logic                        q_br_cc,
  input  logic                        q_ld_reg,
  input  logic [$clog2(NUM_REGS)-1:0] q_drid,
  input  logic                        q_ld_cc,
  output logic                        dep_stall,
  output logic [NUM_REGS-1:0]         pend_mask,
  output logic                        cc_pending,
  output logic                        err_underflow
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0]    reg_cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    reg_cnt_d [NUM_REGS];
  logic [CNT_W-1:0]    cc_cnt_q, cc_cnt_d;
  logic [NUM_REGS-1:0] pend_mask_q, pend_mask_d;
  logic                cc_pending_q, cc_pending_d;
  logic                err_underflow_q, err_underflow_d;

  // Simultaneous inc and dec cancel; increments saturate rather than wrap.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    cnt_step = cnt;
    if (inc && !dec && cnt != CntMax) begin
      cnt_step = cnt + CNT_W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt_step = cnt - CNT_W'(1);
    end
  endfunction

  always_comb begin
    logic inc, dec, uf;
    uf = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc = issue & issue_ld_reg & (issue_drid == IdxW'(r));
      dec = retire & retire_ld_reg & (retire_drid == IdxW'(r));
      reg_cnt_d[r] = cnt_step(reg_cnt_q[r], inc, dec);
      if (dec && !inc && reg_cnt_q[r] == '0) uf = 1'b1;
    end
    inc = issue & issue_ld_cc;
    dec = retire & retire_ld_cc;
    cc_cnt_d = cnt_step(cc_cnt_q, inc, dec);
    if (dec && !inc && cc_cnt_q == '0) uf = 1'b1;

    // Flush discards this cycle's issue/retire, including any underflow they imply.
    if (flush) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) reg_cnt_d[r] = '0;
      cc_cnt_d = '0;
      uf       = 1'b0;
    end

    for (int unsigned r = 0; r < NUM_REGS; r++) pend_mask_d[r] = (reg_cnt_d[r] != '0);
    cc_pending_d    = (cc_cnt_d != '0);
    err_underflow_d = err_underflow_q | uf;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) reg_cnt_q[r] <= '0;
      cc_cnt_q        <= '0;
      pend_mask_q     <= '0;
      cc_pending_q    <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) reg_cnt_q[r] <= reg_cnt_d[r];
      cc_cnt_q        <= cc_cnt_d;
      pend_mask_q     <= pend_mask_d;
      cc_pending_q    <= cc_pending_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  always_comb begin
    dep_stall = 1'b0;
    if (q_valid) begin
      dep_stall = (q_sr1_needed && reg_cnt_q[q_sr1] != '0) ||
                  (q_sr2_needed && reg_cnt_q[q_sr2] != '0) ||
                  (q_br_cc      && cc_cnt_q != '0)         ||
                  (q_ld_reg     && reg_cnt_q[q_drid] == CntMax) ||
                  (q_ld_cc      && cc_cnt_q == CntMax);
    end
  end

  assign pend_mask     = pend_mask_q;
  assign cc_pending    = cc_pending_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_lc3b_scoreboard.sv
// Directed bench for lc3b_scoreboard: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_lc3b_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       issue, issue_ld_reg, issue_ld_cc;
  logic [2:0] issue_drid;
  logic       retire, retire_ld_reg, retire_ld_cc;
  logic [2:0] retire_drid;
  logic       flush;
  logic       q_valid, q_sr1_needed, q_sr2_needed, q_br_cc, q_ld_reg, q_ld_cc;
  logic [2:0] q_sr1, q_sr2, q_drid;
  logic       dep_stall;
  logic [7:0] pend_mask;
  logic       cc_pending;
  logic       err_underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lc3b_scoreboard #(.NUM_REGS(8), .CNT_W(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue        (issue),
    .issue_ld_reg (issue_ld_reg),
    .issue_drid   (issue_drid),
    .issue_ld_cc  (issue_ld_cc),
    .retire       (retire),
    .retire_ld_reg(retire_ld_reg),
    .retire_drid  (retire_drid),
    .retire_ld_cc (retire_ld_cc),
    .flush        (flush),
    .q_valid      (q_valid),
    .q_sr1        (q_sr1),
    .q_sr1_needed (q_sr1_needed),
    .q_sr2        (q_sr2),
    .q_sr2_needed (q_sr2_needed),
    .q_br_cc      (q_br_cc),
    .q_ld_reg     (q_ld_reg),
    .q_drid       (q_drid),
    .q_ld_cc      (q_ld_cc),
    .dep_stall    (dep_stall),
    .pend_mask    (pend_mask),
    .cc_pending   (cc_pending),
    .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic ldr, input logic [2:0] d, input logic ldc);
    issue = v; issue_ld_reg = ldr; issue_drid = d; issue_ld_cc = ldc;
  endtask

  task automatic set_retire(input logic v, input logic ldr, input logic [2:0] d, input logic ldc);
    retire = v; retire_ld_reg = ldr; retire_drid = d; retire_ld_cc = ldc;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    set_issue(0, 0, 0, 0);
    set_retire(0, 0, 0, 0);
    q_valid = 0; q_sr1 = 0; q_sr1_needed = 0; q_sr2 = 0; q_sr2_needed = 0;
    q_br_cc = 0; q_ld_reg = 0; q_drid = 0; q_ld_cc = 0;
    tick(); tick();
    reset_n = 1'b1;

    // Reset state
    q_valid = 1; q_sr1 = 3; q_sr1_needed = 1;
    #1;
    chk("rst_stall", {7'b0, dep_stall}, 8'h00);
    chk("rst_mask", pend_mask, 8'h00);
    chk("rst_cc", {7'b0, cc_pending}, 8'h00);
    chk("rst_err", {7'b0, err_underflow}, 8'h00);

    // ADD R3 issues, R3 and CC become pending
    set_issue(1, 1, 3, 1);
    tick();
    set_issue(0, 0, 0, 0);
    #1;
    chk("add_stall", {7'b0, dep_stall}, 8'h01);
    chk("add_mask", pend_mask, 8'h08);
    chk("add_cc", {7'b0, cc_pending}, 8'h01);
    tick();
    chk("add_stall_c3", {7'b0, dep_stall}, 8'h01);
    // Retire cycle still stalls; released the cycle after
    set_retire(1, 1, 3, 1);
    #1;
    chk("ret_stall_same", {7'b0, dep_stall}, 8'h01);
    tick();
    set_retire(0, 0, 0, 0);
    #1;
    chk("ret_stall_next", {7'b0, dep_stall}, 8'h00);
    chk("ret_mask", pend_mask, 8'h00);
    chk("ret_cc", {7'b0, cc_pending}, 8'h00);

    // Three writers to R5 saturate; a fourth writer to R5 must stall
    q_sr1_needed = 0;
    set_issue(1, 1, 5, 0);
    tick(); tick();
    set_issue(0, 0, 0, 0);
    q_ld_reg = 1; q_drid = 5;
    #1;
    chk("r5_cnt2_nostall", {7'b0, dep_stall}, 8'h00);
    set_issue(1, 1, 5, 0);
    tick();
    set_issue(0, 0, 0, 0);
    #1;
    chk("r5_sat_stall", {7'b0, dep_stall}, 8'h01);
    chk("r5_mask", pend_mask, 8'h20);
    set_retire(1, 1, 5, 0);
    tick();
    set_retire(0, 0, 0, 0);
    #1;
    chk("r5_ret1_stall", {7'b0, dep_stall}, 8'h00);
    chk("r5_ret1_mask", pend_mask, 8'h20);
    set_retire(1, 1, 5, 0);
    tick(); tick();
    set_retire(0, 0, 0, 0);
    #1;
    chk("r5_drained", pend_mask, 8'h00);
    q_ld_reg = 0;

    // Same-cycle issue and retire on R2 nets to zero
    set_issue(1, 1, 2, 0);
    tick();
    set_retire(1, 1, 2, 0);
    tick();
    set_issue(0, 0, 0, 0);
    set_retire(0, 0, 0, 0);
    #1;
    chk("r2_net_mask", pend_mask, 8'h04);
    chk("r2_net_err", {7'b0, err_underflow}, 8'h00);

    // CC-only writer, then a BR waiting on CC
    set_issue(1, 0, 0, 1);
    tick();
    set_issue(0, 0, 0, 0);
    #1;
    chk("cc_only", {7'b0, cc_pending}, 8'h01);
    chk("cc_only_mask", pend_mask, 8'h04);
    q_br_cc = 1;
    #1;
    chk("br_stall", {7'b0, dep_stall}, 8'h01);
    q_valid = 0;
    #1;
    chk("invalid_nostall", {7'b0, dep_stall}, 8'h00);
    q_valid = 1; q_br_cc = 0;
    #1;
    chk("br_clear_nostall", {7'b0, dep_stall}, 8'h00);

    // Same-cycle CC issue and retire nets to zero (cc_cnt stays 1)
    set_issue(1, 0, 0, 1);
    set_retire(1, 0, 0, 1);
    tick();
    set_issue(0, 0, 0, 0);
    set_retire(0, 0, 0, 0);
    #1;
    chk("cc_net", {7'b0, cc_pending}, 8'h01);

    // Pending R1, R4, R2, CC; flush with concurrent retire R1 and issue R7
    set_issue(1, 1, 1, 0);
    tick();
    set_issue(1, 1, 4, 0);
    tick();
    set_issue(0, 0, 0, 0);
    #1;
    chk("pre_flush_mask", pend_mask, 8'h16);
    flush = 1;
    set_retire(1, 1, 1, 0);
    set_issue(1, 1, 7, 1);
    tick();
    flush = 0;
    set_retire(0, 0, 0, 0);
    set_issue(0, 0, 0, 0);
    #1;
    chk("flush_mask", pend_mask, 8'h00);
    chk("flush_cc", {7'b0, cc_pending}, 8'h00);
    chk("flush_err", {7'b0, err_underflow}, 8'h00);

    // CC saturation stall for a CC writer in decode
    q_ld_cc = 1;
    set_issue(1, 0, 0, 1);
    tick(); tick();
    set_issue(0, 0, 0, 0);
    #1;
    chk("cc_cnt2_nostall", {7'b0, dep_stall}, 8'h00);
    set_issue(1, 0, 0, 1);
    tick();
    set_issue(0, 0, 0, 0);
    #1;
    chk("cc_sat_stall", {7'b0, dep_stall}, 8'h01);
    q_ld_cc = 0;
    flush = 1;
    tick();
    flush = 0;

    // Increment at saturation holds at 3: three retires drain R0 without underflow
    set_issue(1, 1, 0, 0);
    tick(); tick(); tick(); tick();
    set_issue(0, 0, 0, 0);
    set_retire(1, 1, 0, 0);
    tick(); tick();
    set_retire(0, 0, 0, 0);
    #1;
    chk("sat_hold_mask2", pend_mask, 8'h01);
    set_retire(1, 1, 0, 0);
    tick();
    set_retire(0, 0, 0, 0);
    #1;
    chk("sat_hold_mask", pend_mask, 8'h00);
    chk("sat_hold_err", {7'b0, err_underflow}, 8'h00);

    // Underflow on R6 is sticky through flush, cleared by reset
    set_retire(1, 1, 6, 0);
    tick();
    set_retire(0, 0, 0, 0);
    #1;
    chk("uf_set", {7'b0, err_underflow}, 8'h01);
    chk("uf_mask", pend_mask, 8'h00);
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("uf_sticky", {7'b0, err_underflow}, 8'h01);
    reset_n = 0;
    tick();
    reset_n = 1;
    #1;
    chk("uf_reset", {7'b0, err_underflow}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3b_scoreboard.md
Name: lc3b_scoreboard

Overview:
- Writer-side hazard tracker for the lc3b pipeline.
- Records pending destination-register and condition-code writes when an instruction issues into EX, and releases them when it commits in WB.
- From that state it drives the decode-stage dependency stall, replacing per-stage drid/ld_reg comparisons.
- Sits beside decode; issue port fed from decode→EX latch, retire port from WB commit.

Parameters:
- NUM_REGS, 8, architectural registers tracked (index width 3, lc3b_reg).
- CNT_W, 2, per-entry pending-counter width; max in-flight writers per entry = 2^CNT_W-1 (3).

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous reset, active low
- issue  input  1  instruction enters EX this cycle
- issue_ld_reg  input  1  issuing instruction writes a register
- issue_drid  input  3  its destination register
- issue_ld_cc  input  1  issuing instruction writes CC
- retire  input  1  instruction commits in WB this cycle
- retire_ld_reg  input  1  committing instruction writes a register
- retire_drid  input  3  its destination register
- retire_ld_cc  input  1  committing instruction writes CC
- flush  input  1  squash all in-flight instructions
- q_valid  input  1  decode holds a valid instruction
- q_sr1  input  3  source 1
- q_sr1_needed  input  1  source 1 read
- q_sr2  input  3  source 2
- q_sr2_needed  input  1  source 2 read
- q_br_cc  input  1  decode is BR with branch_stall set
- q_ld_reg  input  1  decode instruction will write a register
- q_drid  input  3  its destination
- q_ld_cc  input  1  decode instruction will write CC
- dep_stall  output  1  hold decode (combinational from registered state)
- pend_mask  output  8  bit r = register r count nonzero (registered)
- cc_pending  output  1  CC count nonzero (registered)
- err_underflow  output  1  sticky: retire against zero count

Behaviour:
- State: reg_cnt[0..7] and cc_cnt, each CNT_W bits. err_underflow is 1 bit.
- Reset (reset_n=0 at posedge): all counts 0; pend_mask=0; cc_pending=0; err_underflow=0. dep_stall is therefore 0 the next cycle.
- Inc for an entry = issue & (issue_ld_reg & issue_drid==r, or issue_ld_cc for CC).
- Dec for an entry = retire & the matching retire fields.
- Per entry per cycle:
  - inc&dec: unchanged.
  - inc only: +1.
  - dec only: -1 if count>0.
  - dec only at count=0: stays 0; set err_underflow.
- Issue and retire on the same register in the same cycle: net zero.
- Issue and retire both writing CC in the same cycle: net zero.
- Increment at saturation (count=max): count holds. This is an upstream protocol violation, prevented by the saturation stall below.
- flush=1: all counts cleared to 0 next cycle. Issue and retire in that cycle are ignored. err_underflow is unaffected. Reset has priority over flush.
- Update latency: one cycle. No same-cycle bypass, so a register retiring in cycle N still stalls the reader in cycle N and is released in N+1.
- dep_stall=1 iff q_valid and any of the following:
  - (a) q_sr1_needed & reg_cnt[q_sr1]!=0
  - (b) q_sr2_needed & reg_cnt[q_sr2]!=0
  - (c) q_br_cc & cc_cnt!=0
  - (d) q_ld_reg & reg_cnt[q_drid]==max
  - (e) q_ld_cc & cc_cnt==max
- q_valid=0 forces dep_stall=0.
- pend_mask and cc_pending reflect counts after the current edge's update, registered.
- err_underflow clears only on reset.

Test Plan:
- Reset with reset_n=0 for 2 cycles, then query q_sr1=3 needed → dep_stall=0, pend_mask=8'h00, cc_pending=0.
- Issue ADD R3 (ld_reg, drid=3, ld_cc) in cycle 1. In cycle 2, query sr1=3 → dep_stall=1, pend_mask=8'h08, cc_pending=1. Retire R3 in cycle 4 → dep_stall still 1 in cycle 4, 0 in cycle 5.
- Issue writers to R5 in three consecutive cycles → reg_cnt[5]=3. Query q_ld_reg, drid=5 with no sources → dep_stall=1. One retire of R5 → next cycle dep_stall=0, pend_mask[5]=1.
- Same cycle: issue drid=2 and retire drid=2 with reg_cnt[2]=1 → count stays 1, pend_mask[2]=1. Issue ld_cc alone with cc_cnt=0 → cc_pending=1. Then BR query with q_br_cc=1 → dep_stall=1.
- Pending on R1, R4 and CC, then flush=1 while retire R1 is also asserted → next cycle pend_mask=0, cc_pending=0, err_underflow=0.
- Retire drid=6 with reg_cnt[6]=0 → err_underflow=1 and stays 1 through a flush. Clears after reset_n=0.
